// File: rtl/design_sel_pkg.sv
// design_sel_pkg: shared types and constants for the design selection
// controller.
//   rx_state_t   : serial frame receiver states
//   sw_state_t   : design switchover states
//   NUM_DESIGNS  : highest selectable design number (designs 1..NUM_DESIGNS)
//   SEL_W        : width of the design_select bus
//   frame_ok()   : key / range check of a received 8-bit frame
package design_sel_pkg;

   localparam int NUM_DESIGNS = 12;
   localparam int SEL_W       = 4;

   typedef enum logic [1:0] {
      RX_IDLE,
      RX_SHIFT,
      RX_DONE
   } rx_state_t;

   typedef enum logic {
      SW_RUN,
      SW_GUARD
   } sw_state_t;

   // Upper nibble must carry the key, lower nibble must be a design number
   // (0 = no design is legal).
   function automatic logic frame_ok(input logic [7:0] frame,
                                     input logic [3:0] key);
      return (frame[7:4] == key) && (frame[3:0] <= SEL_W'(NUM_DESIGNS));
   endfunction

endpackage

// File: rtl/sync_edge.sv
// sync_edge: two-flop synchronizer for one asynchronous input followed by a
// third flop used for edge detection.
//   clk   : system clock
//   rst   : synchronous active-high reset, loads all flops with IDLE
//   din   : asynchronous input
//   level : synchronized level of din
//   rise  : one-cycle pulse on a synchronized rising edge
//   fall  : one-cycle pulse on a synchronized falling edge
module sync_edge #(
   parameter logic IDLE = 1'b0
) (
   input  logic clk,
   input  logic rst,
   input  logic din,
   output logic level,
   output logic rise,
   output logic fall
);

   logic s1;
   logic s2;
   logic s3;

   always_ff @(posedge clk) begin
      if (rst) begin
         s1 <= IDLE;
         s2 <= IDLE;
         s3 <= IDLE;
      end else begin
         s1 <= din;
         s2 <= s1;
         s3 <= s2;
      end
   end

   assign level = s2;
   assign rise  = s2 & ~s3;
   assign fall  = ~s2 & s3;

endmodule

// File: rtl/design_select_ctrl.sv
// design_select_ctrl: receives 8-bit configuration frames over a slow
// asynchronous serial link and switches the active design with a guard
// period of GUARD_CYCLES clocks during which no design is selected.
//   clk           : system clock, rising edge
//   rst           : synchronous active-high reset
//   cfg_csb       : async frame enable, active low
//   cfg_sck       : async bit clock, data taken on its rising edge
//   cfg_sdi       : async serial data, MSB first
//   design_select : registered selection, 0 = none, 1..12 = design N
//   busy          : high during the guard period
//   frame_err     : one-cycle pulse on a rejected frame
module design_select_ctrl
   import design_sel_pkg::*;
#(
   parameter int         GUARD_CYCLES = 16,
   parameter logic [3:0] KEY          = 4'b1010
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cfg_csb,
   input  logic             cfg_sck,
   input  logic             cfg_sdi,
   output logic [SEL_W-1:0] design_select,
   output logic             busy,
   output logic             frame_err
);

   localparam int GW = $clog2(GUARD_CYCLES + 1);

   logic csb_level, csb_rise, csb_fall;
   logic sck_rise;
   logic sdi_level;
   logic sck_level_unused, sck_fall_unused;
   logic sdi_rise_unused, sdi_fall_unused;

   sync_edge #(.IDLE(1'b1)) u_sync_csb (
      .clk(clk), .rst(rst), .din(cfg_csb),
      .level(csb_level), .rise(csb_rise), .fall(csb_fall)
   );

   sync_edge #(.IDLE(1'b0)) u_sync_sck (
      .clk(clk), .rst(rst), .din(cfg_sck),
      .level(sck_level_unused), .rise(sck_rise), .fall(sck_fall_unused)
   );

   sync_edge #(.IDLE(1'b0)) u_sync_sdi (
      .clk(clk), .rst(rst), .din(cfg_sdi),
      .level(sdi_level), .rise(sdi_rise_unused), .fall(sdi_fall_unused)
   );

   rx_state_t        rx_state;
   logic [7:0]       shift_reg;
   logic [3:0]       bit_cnt;
   logic [1:0]       settle;
   logic             armed;

   sw_state_t        sw_state;
   logic [SEL_W-1:0] target;
   logic [GW-1:0]    guard_cnt;

   logic frame_end;
   logic frame_good;
   logic frame_bad;

   // The synchronizers are reset to the idle level, so a csb that is already
   // low when reset is released shows up as a falling edge a couple of
   // cycles later. armed only rises once the synchronizers have settled and
   // csb has been seen high, so such a frame is ignored until a fresh edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         rx_state  <= RX_IDLE;
         shift_reg <= '0;
         bit_cnt   <= '0;
         settle    <= '0;
         armed     <= 1'b0;
      end else begin
         if (settle != 2'd3) settle <= settle + 2'd1;
         armed <= (settle == 2'd3) && csb_level;
         case (rx_state)
            RX_IDLE: begin
               if (csb_fall && armed) begin
                  rx_state <= RX_SHIFT;
                  bit_cnt  <= '0;
               end
            end
            RX_SHIFT: begin
               if (csb_rise) begin
                  rx_state <= RX_IDLE;
               end else if (sck_rise) begin
                  shift_reg <= {shift_reg[6:0], sdi_level};
                  bit_cnt   <= bit_cnt + 4'd1;
                  if (bit_cnt == 4'd7) rx_state <= RX_DONE;
               end
            end
            RX_DONE: begin
               if (csb_rise) rx_state <= RX_IDLE;
            end
            default: rx_state <= RX_IDLE;
         endcase
      end
   end

   assign frame_end  = (rx_state == RX_DONE) && csb_rise;
   assign frame_good = frame_end && frame_ok(shift_reg, KEY);
   assign frame_bad  = ((rx_state == RX_SHIFT) && csb_rise) ||
                       (frame_end && !frame_ok(shift_reg, KEY));

   always_ff @(posedge clk) begin
      if (rst) begin
         sw_state      <= SW_RUN;
         design_select <= '0;
         busy          <= 1'b0;
         frame_err     <= 1'b0;
         target        <= '0;
         guard_cnt     <= '0;
      end else begin
         frame_err <= frame_bad;
         case (sw_state)
            SW_RUN: begin
               if (frame_good && (shift_reg[3:0] != design_select)) begin
                  target        <= shift_reg[3:0];
                  guard_cnt     <= GW'(GUARD_CYCLES);
                  design_select <= '0;
                  busy          <= 1'b1;
                  sw_state      <= SW_GUARD;
               end
            end
            SW_GUARD: begin
               if (frame_good) begin
                  // latest frame wins: new target, guard restarts
                  target    <= shift_reg[3:0];
                  guard_cnt <= GW'(GUARD_CYCLES);
               end else if (guard_cnt == GW'(1)) begin
                  design_select <= target;
                  busy          <= 1'b0;
                  sw_state      <= SW_RUN;
               end else begin
                  guard_cnt <= guard_cnt - GW'(1);
               end
            end
            default: sw_state <= SW_RUN;
         endcase
      end
   end

endmodule
